// File: rtl/lampFPU_pkg.sv
// Shared lampFPU definitions for the sqrt issue/retire controller: FSM states,
// bfloat16 constants, operand classification and round-to-nearest-even packing.
package lampFPU_pkg;

  localparam int          LAMP_FLOAT_E_BIAS = 127;
  localparam logic [7:0]  LAMP_FLOAT_E_MAX  = 8'(2 * LAMP_FLOAT_E_BIAS + 1);
  localparam logic [15:0] QNAN_BF16         = 16'h7FC0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } sqrt_state_e;

  typedef struct packed {
    logic       sign;
    logic [7:0] ext_exp;
    logic [7:0] ext_mant;
    logic       is_inf;
    logic       is_zero;
    logic       is_snan;
    logic       is_qnan;
  } op_class_t;

  // Denormals are flushed to zero; the sign survives so -0 stays distinguishable.
  function automatic op_class_t FUNC_classifyOp(input logic [15:0] op);
    op_class_t  c;
    logic [7:0] e;
    logic [6:0] f;
    logic       nan;
    e          = op[14:7];
    f          = op[6:0];
    nan        = (e == LAMP_FLOAT_E_MAX) && (f != 7'd0);
    c.sign     = op[15];
    c.ext_exp  = e;
    c.ext_mant = {e != 8'd0, f};
    c.is_inf   = (e == LAMP_FLOAT_E_MAX) && (f == 7'd0);
    c.is_zero  = (e == 8'd0);
    c.is_qnan  = nan & f[6];
    c.is_snan  = nan & ~f[6];
    return c;
  endfunction

  // f holds {hidden, frac[6:0], guard, round, sticky}.
  function automatic logic [15:0] FUNC_rndNearestEven(input logic       s,
                                                      input logic [7:0] e,
                                                      input logic [10:0] f);
    logic       up;
    logic       carry;
    logic       unused_hidden;
    logic [6:0] frac;
    logic [7:0] e_out;
    up = f[2] & (f[1] | f[0] | f[3]);
    {carry, unused_hidden, frac} = {1'b0, f[10:3]} + {8'd0, up};
    e_out = e;
    if (carry) begin
      frac  = 7'd0;
      e_out = (e == LAMP_FLOAT_E_MAX) ? LAMP_FLOAT_E_MAX : e + 8'd1;
    end
    return {s, e_out, frac};
  endfunction

endpackage

// File: rtl/lamp_fpu_sqrt_rnd_pack.sv
// Combinational rounding and packing of the sqrt unit's extended result.
module lamp_fpu_sqrt_rnd_pack
  import lampFPU_pkg::*;
(
  input  logic        i_s,
  input  logic [7:0]  i_e,
  input  logic [10:0] i_f,
  input  logic        i_is_to_round,
  output logic [15:0] o_res
);

  logic [15:0] w_rounded;

  assign w_rounded = FUNC_rndNearestEven(i_s, i_e, i_f);
  assign o_res     = i_is_to_round ? w_rounded : {i_s, i_e, i_f[9:3]};

endmodule

// File: rtl/lamp_fpu_sqrt_ctrl.sv
// Issue/retire controller for the lampFPU square-root unit.
// Optional WAIT watchdog enabled by defining LAMP_SQRT_TIMEOUT_EN.
module lamp_fpu_sqrt_ctrl
  import lampFPU_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] op_i,
  input  logic        inv_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_o,
  output logic        res_nv_o,
  output logic        res_timeout_o,
  output logic        doSqrt_o,
  output logic        invSqrt_o,
  output logic        signum_op_o,
  output logic [7:0]  extExp_op_o,
  output logic [7:0]  extMant_op_o,
  output logic        isInf_op_o,
  output logic        isZero_op_o,
  output logic        isSNAN_op_o,
  output logic        isQNAN_op_o,
  input  logic        valid_i,
  input  logic        isToRound_i,
  input  logic        s_res_i,
  input  logic [7:0]  e_res_i,
  input  logic [11:0] f_res_i,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; in_ready_o is high only in IDLE and res_valid_o only in DONE.

  sqrt_state_e r_state;
  op_class_t   r_op;
  logic        r_in_ready;
  logic        r_do_sqrt;
  logic        r_inv;
  logic        r_s_res;
  logic [7:0]  r_e_res;
  logic [10:0] r_f_res;
  logic        r_is_to_round;
  logic        r_res_valid;
  logic [15:0] r_res;
  logic        r_res_nv;
  logic        r_res_timeout;

  op_class_t   w_class;
  logic [15:0] w_rnd_res;
  logic        w_nv;
  logic        w_unused_carry;

  assign w_class        = FUNC_classifyOp(op_i);
  // The unit's carry bit is not needed: rounding re-derives it from hidden+frac.
  assign w_unused_carry = f_res_i[11];
  assign w_nv = r_op.is_snan |
                (r_op.sign & ~r_op.is_zero & ~r_op.is_snan & ~r_op.is_qnan);

  lamp_fpu_sqrt_rnd_pack u_rnd_pack (
    .i_s           (r_s_res),
    .i_e           (r_e_res),
    .i_f           (r_f_res),
    .i_is_to_round (r_is_to_round),
    .o_res         (w_rnd_res)
  );

`ifdef LAMP_SQRT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_op          <= '0;
      r_in_ready    <= 1'b1;
      r_do_sqrt     <= 1'b0;
      r_inv         <= 1'b0;
      r_s_res       <= 1'b0;
      r_e_res       <= 8'd0;
      r_f_res       <= 11'd0;
      r_is_to_round <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res         <= 16'd0;
      r_res_nv      <= 1'b0;
      r_res_timeout <= 1'b0;
`ifdef LAMP_SQRT_TIMEOUT_EN
      r_wait_cnt    <= '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_op       <= w_class;
            r_inv      <= inv_i;
            r_in_ready <= 1'b0;
            r_do_sqrt  <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_do_sqrt <= 1'b0;
          r_state   <= ST_WAIT;
`ifdef LAMP_SQRT_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (valid_i) begin
            r_s_res       <= s_res_i;
            r_e_res       <= e_res_i;
            r_f_res       <= f_res_i[10:0];
            r_is_to_round <= isToRound_i;
            r_state       <= ST_ROUND;
          end
`ifdef LAMP_SQRT_TIMEOUT_EN
          else if (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_res         <= QNAN_BF16;
            r_res_nv      <= 1'b0;
            r_res_timeout <= 1'b1;
            r_res_valid   <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        ST_ROUND: begin
          r_res         <= w_rnd_res;
          r_res_nv      <= w_nv;
          r_res_timeout <= 1'b0;
          r_res_valid   <= 1'b1;
          r_state       <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o    = r_in_ready;
  assign res_valid_o   = r_res_valid;
  assign res_o         = r_res;
  assign res_nv_o      = r_res_nv;
`ifdef LAMP_SQRT_TIMEOUT_EN
  assign res_timeout_o = r_res_timeout;
`else
  assign res_timeout_o = 1'b0;
`endif
  assign doSqrt_o      = r_do_sqrt;
  assign invSqrt_o     = r_inv;
  assign signum_op_o   = r_op.sign;
  assign extExp_op_o   = r_op.ext_exp;
  assign extMant_op_o  = r_op.ext_mant;
  assign isInf_op_o    = r_op.is_inf;
  assign isZero_op_o   = r_op.is_zero;
  assign isSNAN_op_o   = r_op.is_snan;
  assign isQNAN_op_o   = r_op.is_qnan;
  assign dbg_state_o   = r_state;

endmodule
